// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from an upstream FIFO and sends them as 8N1/8N2 frames.
// The tx line is registered; back-to-back frames run with no idle gap between them.
module uart_tx #(
    parameter int B            = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fifo_empty,
    input  logic [B-1:0] fifo_r_data,
    output logic         fifo_rd,
    output logic         tx,
    output logic         busy,
    output logic         tx_done_tick
);

    localparam int TW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int NW = (B > 1) ? $clog2(B) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   tick_q;
    logic [NW-1:0]   bit_q;
    logic [B-1:0]    shift_q;
    logic            tx_q;
    logic            bit_end;
    logic            stop_end;

    assign bit_end  = (tick_q == TW'(CLKS_PER_BIT - 1));
    assign stop_end = (tick_q == TW'(STOP_BITS * CLKS_PER_BIT - 1));

    assign tx_done_tick = (state_q == STOP) && stop_end;
    assign busy         = (state_q != IDLE);
    assign tx           = tx_q;

    // Held low during reset so no queued word is lost while the block is held.
    assign fifo_rd = ~reset & ~fifo_empty &
                     ((state_q == IDLE) | tx_done_tick);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fifo_rd) begin
                        shift_q <= fifo_r_data;
                        tick_q  <= '0;
                        state_q <= START;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tick_q  <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        tick_q  <= '0;
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == NW'(B - 1)) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (stop_end) begin
                        tick_q <= '0;
                        if (fifo_rd) begin
                            shift_q <= fifo_r_data;
                            state_q <= START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter that drains the byte FIFO from its read side.
- Pops one word when the FIFO is non-empty and frames it as 8N1/8N2 UART: start bit, data bits LSB-first, stop bit(s).
- Drives the tx line at a fixed clocks-per-bit rate.
- Sits directly downstream of the FIFO: consumes its empty/r_data outputs and drives its rd input.

Parameters:
- B, 8, data bits per frame; must match the FIFO word width.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_r_data  input  B  FIFO head word; valid combinationally whenever fifo_empty=0.
- fifo_rd  output  1  one-cycle pop strobe to the FIFO.
- tx  output  1  serial line; idle high; registered.
- busy  output  1  high while a frame is in progress (state != IDLE).
- tx_done_tick  output  1  one-cycle pulse in the final cycle of each frame's stop period.

Behaviour:
- Reset values: state=IDLE, tx=1, fifo_rd=0, busy=0, tx_done_tick=0, bit counter=0, tick counter=0, shift register=0.
- Reset mid-frame: tx returns to 1 immediately (asynchronous). The frame is abandoned with no done tick. The popped word is lost; unpopped words stay in the FIFO.
- State IDLE: tx=1.
  - fifo_rd = ~fifo_empty, combinational from state and fifo_empty only.
  - On an edge with fifo_rd=1: load fifo_r_data into the shift register, clear the tick counter, go to START.
- State START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- State DATA:
  - tx = shift register bit 0 for CLKS_PER_BIT cycles, then shift right by 1 and increment the bit index.
  - After bit B-1, go to STOP.
- State STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done_tick=1 in the last cycle of this period.
  - If fifo_empty=0 in that last cycle: assert fifo_rd in that same cycle, load the next word, go directly to START. Back-to-back frames therefore have no idle gap.
  - Otherwise go to IDLE.
- Frame timing: period is exactly (1+B+STOP_BITS)*CLKS_PER_BIT cycles.
  - tx changes on the edge after the capture edge (registered output), giving a one-cycle pipeline latency from fifo_rd to the start bit.
- fifo_rd rules:
  - Never asserted when fifo_empty=1.
  - Never asserted in START or DATA, or in any STOP cycle except the last.
  - At most one pulse per frame.
- Counter widths:
  - Tick counter is clog2(STOP_BITS*CLKS_PER_BIT) bits.
  - Bit index is clog2(B) bits.
  - No wrap-around is used for control; terminal counts are compared explicitly.
- busy: 1 from the edge after the capture edge through the last stop cycle. Stays 1 across back-to-back frames.

Test Plan (B=8, CLKS_PER_BIT=4, STOP_BITS=1 unless stated):
1. Assert reset with FIFO empty, release, run 20 cycles -> tx=1, fifo_rd=0, busy=0, tx_done_tick=0 throughout.
2. FIFO holds 0xA5, empty=0 at cycle 0 -> expected response:
   - fifo_rd=1 exactly in cycle 0.
   - tx=0 for cycles 1-4, then bits 1,0,1,0,0,1,0,1 at 4 cycles each (cycles 5-36), stop high cycles 37-40.
   - tx_done_tick=1 only in cycle 40; busy=0 from cycle 41.
3. FIFO holds 0x55 then 0x0F -> expected response:
   - Second fifo_rd pulses in cycle 40 together with tx_done_tick.
   - Start bit of 0x0F begins cycle 41 with no idle-high gap.
   - Second tx_done_tick in cycle 80; exactly two fifo_rd pulses total.
4. Hold fifo_empty=1 for 100 cycles, then write one word -> no fifo_rd during the empty period; fifo_rd in the first cycle with empty=0; frame follows as in scenario 2.
5. Assert reset during bit 3 of a 0xFF frame, with a second word still queued -> expected response:
   - tx=1 in the same cycle reset rises; no tx_done_tick.
   - After release: fifo_rd on the first cycle, and the queued word is transmitted intact.
6. STOP_BITS=2, single word 0x00 -> tx low for cycles 1-36, high for cycles 37-44; tx_done_tick only in cycle 44; frame length 44 cycles.
